// File: rtl/wb_host_pkg.sv
// Shared types and default constants for the Wishbone host master.
package wb_host_pkg;

  localparam int ADR_W_DEF       = 8;
  localparam int DAT_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus watchdog: counts BUS cycles without ACK and flags the cycle in which
// the count would reach TIMEOUT_CYC, so the abort lands on that cycle's edge.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic CLK_I,
  input  logic RST_N_I,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt;

  // Clear on BUS entry, count every stalled BUS cycle.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 16'd1;
  end

  assign expired = enable && (cnt == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_host_master.sv
// Host-command to Wishbone classic master. One command in flight; the
// response is held until the host consumes it.
// Optional bus watchdog: define WB_HOST_MASTER_TIMEOUT_EN to abort stalled
// cycles after TIMEOUT_CYC BUS cycles with RSP_ERR=1.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int DAT_W       = DAT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             CLK_I,
  input  logic             RST_N_I,
  input  logic             HOST_REQ,
  input  logic             HOST_WE,
  input  logic [ADR_W-1:0] HOST_ADR,
  input  logic [DAT_W-1:0] HOST_WDAT,
  output logic             HOST_RDY,
  output logic             RSP_VALID,
  output logic [DAT_W-1:0] RSP_DAT,
  output logic             RSP_ERR,
  output logic             RSP_TGD,
  input  logic             RSP_ACK,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  output logic [ADR_W-1:0] ADR_O,
  output logic [DAT_W-1:0] DAT_O,
  input  logic [DAT_W-1:0] DAT_I,
  input  logic             ACK_I,
  input  logic             TGD_I
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 1..65535");
  end

  state_e state, state_n;
  logic   accept, bus_ack, bus_expired;

  assign accept  = HOST_REQ && HOST_RDY;
  assign bus_ack = (state == ST_BUS) && ACK_I;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  logic rsp_err_q;

  wb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .CLK_I   (CLK_I),
    .RST_N_I (RST_N_I),
    .clear   (accept),
    .enable  ((state == ST_BUS) && !ACK_I),
    .expired (bus_expired)
  );

  // Error flag: set on watchdog abort, cleared on a normal ACK (ACK wins).
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I)         rsp_err_q <= 1'b0;
    else if (bus_ack)     rsp_err_q <= 1'b0;
    else if (bus_expired) rsp_err_q <= 1'b1;
  end

  assign RSP_ERR = rsp_err_q;
`else
  assign bus_expired = 1'b0;
  assign RSP_ERR     = 1'b0;
`endif

  // State register; async reset discards any in-flight command.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state: ACK_I only matters in BUS, HOST_REQ only in IDLE.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (HOST_REQ)               state_n = ST_BUS;
      ST_BUS:  if (ACK_I || bus_expired)   state_n = ST_RESP;
      ST_RESP: if (RSP_ACK)                state_n = ST_IDLE;
      default:                             state_n = ST_IDLE;
    endcase
  end

  // Handshake/strobe outputs decoded straight from state so reset drops them at once.
  always_comb begin
    HOST_RDY  = (state == ST_IDLE);
    CYC_O     = (state == ST_BUS);
    STB_O     = (state == ST_BUS);
    RSP_VALID = (state == ST_RESP);
  end

  // Command capture on acceptance; held constant through BUS.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      WE_O  <= 1'b0;
      ADR_O <= '0;
      DAT_O <= '0;
    end else if (accept) begin
      WE_O  <= HOST_WE;
      ADR_O <= HOST_ADR;
      DAT_O <= HOST_WDAT;
    end
  end

  // Response capture on termination; writes and aborts return zero data.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      RSP_DAT <= '0;
      RSP_TGD <= 1'b0;
    end else if (bus_ack) begin
      RSP_DAT <= WE_O ? '0 : DAT_I;
      RSP_TGD <= TGD_I;
    end else if (bus_expired) begin
      RSP_DAT <= '0;
      RSP_TGD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master. Expected responses are queued at
// command issue and compared when the host consumes them. The timeout
// scenario runs only when WB_HOST_MASTER_TIMEOUT_EN is defined.
module tb_wb_host_master;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        CLK_I = 1'b0;
  logic        RST_N_I = 1'b0;
  logic        HOST_REQ = 1'b0, HOST_WE = 1'b0;
  logic [7:0]  HOST_ADR = '0;
  logic [31:0] HOST_WDAT = '0;
  logic        HOST_RDY, RSP_VALID, RSP_ERR, RSP_TGD;
  logic [31:0] RSP_DAT;
  logic        RSP_ACK = 1'b0;
  logic        CYC_O, STB_O, WE_O;
  logic [7:0]  ADR_O;
  logic [31:0] DAT_O;
  wire  [31:0] DAT_I;
  wire         ACK_I, TGD_I;

  wb_host_master #(.ADR_W(8), .DAT_W(32), .TIMEOUT_CYC(TO)) dut (
    .CLK_I(CLK_I), .RST_N_I(RST_N_I),
    .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADR(HOST_ADR), .HOST_WDAT(HOST_WDAT),
    .HOST_RDY(HOST_RDY),
    .RSP_VALID(RSP_VALID), .RSP_DAT(RSP_DAT), .RSP_ERR(RSP_ERR), .RSP_TGD(RSP_TGD),
    .RSP_ACK(RSP_ACK),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .TGD_I(TGD_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Bridge model: ACK on the ack_delay-th BUS cycle (0 = never).
  int          bcnt = 0;
  int          ack_delay = 1;
  logic        bus_ack = 1'b0, spur_ack = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_tgd = 1'b0;

  assign ACK_I = bus_ack | spur_ack;
  assign DAT_I = rd_data;
  assign TGD_I = rd_tgd;

  always @(negedge CLK_I) begin
    if (CYC_O && STB_O) begin
      bcnt    = bcnt + 1;
      bus_ack = (bcnt == ack_delay);
    end else begin
      bcnt    = 0;
      bus_ack = 1'b0;
    end
  end

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        tgd;
  } rsp_t;

  rsp_t        sbq[$];
  int          checks = 0, errors = 0;
  logic        cur_we;
  logic [7:0]  cur_adr;
  logic [31:0] cur_wdat;

  task automatic send(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                      input logic [31:0] edat, input logic eerr, input logic etgd);
    rsp_t r;
    @(negedge CLK_I);
    checks++;
    if (HOST_RDY !== 1'b1) begin
      errors++;
      $display("FAIL send_rdy: HOST_RDY got %b want 1", HOST_RDY);
    end
    HOST_REQ = 1'b1; HOST_WE = we; HOST_ADR = adr; HOST_WDAT = wdat;
    cur_we = we; cur_adr = adr; cur_wdat = wdat;
    r.dat = edat; r.err = eerr; r.tgd = etgd;
    sbq.push_back(r);
    @(negedge CLK_I);
    HOST_REQ = 1'b0;
  endtask

  // Called in the first BUS cycle; tracks the bus phase, then checks and consumes the response.
  task automatic collect(input int exp_bus, input int exp_lat, input string nm);
    int   lat = 1, bus = 0;
    bit   bad = 0;
    rsp_t e;
    while (RSP_VALID !== 1'b1 && lat < 500) begin
      if (CYC_O === 1'b1) begin
        bus++;
        if (STB_O !== 1'b1 || ADR_O !== cur_adr || DAT_O !== cur_wdat || WE_O !== cur_we) bad = 1;
      end
      @(negedge CLK_I);
      lat++;
    end
    checks++;
    if (RSP_VALID !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: RSP_VALID got %b want 1 within 500 cycles", nm, RSP_VALID);
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL %s_bus_hold: bus outputs changed, got adr %h want %h", nm, ADR_O, cur_adr); end
    checks++;
    if (bus !== exp_bus) begin errors++; $display("FAIL %s_bus_cycles: got %0d want %0d", nm, bus, exp_bus); end
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat); end
    checks++;
    if (CYC_O !== 1'b0 || STB_O !== 1'b0) begin errors++; $display("FAIL %s_cyc_drop: got %b%b want 00", nm, CYC_O, STB_O); end
    checks++;
    if (sbq.size() == 0) begin
      errors++; $display("FAIL %s_sb_empty: got 0 entries want 1", nm);
    end else begin
      e = sbq.pop_front();
      if (RSP_DAT !== e.dat) begin errors++; $display("FAIL %s_dat: got %h want %h", nm, RSP_DAT, e.dat); end
      checks++;
      if (RSP_ERR !== e.err) begin errors++; $display("FAIL %s_err: got %b want %b", nm, RSP_ERR, e.err); end
      checks++;
      if (RSP_TGD !== e.tgd) begin errors++; $display("FAIL %s_tgd: got %b want %b", nm, RSP_TGD, e.tgd); end
    end
    RSP_ACK = 1'b1;
    @(negedge CLK_I);
    RSP_ACK = 1'b0;
    checks++;
    if (RSP_VALID !== 1'b0 || HOST_RDY !== 1'b1) begin
      errors++; $display("FAIL %s_consume: valid/rdy got %b%b want 01", nm, RSP_VALID, HOST_RDY);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK_I);
    checks++;
    if (CYC_O !== 1'b0 || STB_O !== 1'b0 || WE_O !== 1'b0 || ADR_O !== 8'h0 || DAT_O !== 32'h0) begin
      errors++; $display("FAIL reset_bus: got cyc %b stb %b we %b adr %h dat %h want all 0", CYC_O, STB_O, WE_O, ADR_O, DAT_O);
    end
    checks++;
    if (RSP_VALID !== 1'b0 || RSP_DAT !== 32'h0 || RSP_ERR !== 1'b0 || RSP_TGD !== 1'b0 || HOST_RDY !== 1'b1) begin
      errors++; $display("FAIL reset_rsp: got v %b d %h e %b t %b rdy %b want 0 0 0 0 1", RSP_VALID, RSP_DAT, RSP_ERR, RSP_TGD, HOST_RDY);
    end
    RST_N_I = 1'b1;
  endtask

  task automatic test_write();
    ack_delay = 3; rd_data = 32'h5555_AAAA; rd_tgd = 1'b0;
    send(1'b1, 8'h05, 32'hA5A5_1234, 32'h0, 1'b0, 1'b0);
    collect(3, 4, "write");
  endtask

  task automatic test_read();
    ack_delay = 1; rd_data = 32'hDEAD_BEEF; rd_tgd = 1'b1;
    send(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    collect(1, 2, "read");
  endtask

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    ack_delay = 0; rd_data = 32'h0BAD_0BAD; rd_tgd = 1'b1;
    send(1'b0, 8'h40, 32'h0, 32'h0, 1'b1, 1'b0);
    collect(TO, TO + 1, "timeout_abort");
    ack_delay = TO; rd_data = 32'h1234_5678; rd_tgd = 1'b1;
    send(1'b0, 8'h41, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
    collect(TO, TO + 1, "timeout_ack_wins");
  endtask
`endif

  task automatic test_backpressure();
    int   n = 0;
    bit   bad = 0;
    rsp_t e;
    ack_delay = 1; rd_data = 32'hCAFE_F00D; rd_tgd = 1'b0;
    send(1'b0, 8'h22, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    while (RSP_VALID !== 1'b1 && n < 50) begin @(negedge CLK_I); n++; end
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADR = 8'h77; HOST_WDAT = 32'h7777_7777;
    e = sbq.pop_front();
    for (int i = 0; i < 10; i++) begin
      if (RSP_VALID !== 1'b1 || RSP_DAT !== e.dat || RSP_ERR !== e.err || RSP_TGD !== e.tgd ||
          HOST_RDY !== 1'b0 || CYC_O !== 1'b0) bad = 1;
      @(negedge CLK_I);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_hold: got dat %h rdy %b cyc %b want dat %h rdy 0 cyc 0", RSP_DAT, HOST_RDY, CYC_O, e.dat); end
    checks++;
    if (ADR_O !== 8'h22 || WE_O !== 1'b0) begin errors++; $display("FAIL bp_ignore_req: got adr %h we %b want 22 0", ADR_O, WE_O); end
    HOST_REQ = 1'b0; RSP_ACK = 1'b1;
    @(negedge CLK_I);
    RSP_ACK = 1'b0;
    checks++;
    if (HOST_RDY !== 1'b1 || RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL bp_release: rdy/valid got %b%b want 10", HOST_RDY, RSP_VALID);
    end
  endtask

  task automatic test_reset_mid_bus();
    bit bad = 0;
    ack_delay = 0; rd_data = 32'h3333_3333; rd_tgd = 1'b1;
    send(1'b0, 8'h33, 32'h0, 32'h0, 1'b0, 1'b0);
    void'(sbq.pop_back());
    @(negedge CLK_I);
    #2 RST_N_I = 1'b0;
    #1;
    checks++;
    if (CYC_O !== 1'b0 || STB_O !== 1'b0 || RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL rst_async_drop: cyc/stb/valid got %b%b%b want 000", CYC_O, STB_O, RSP_VALID);
    end
    repeat (2) @(negedge CLK_I);
    RST_N_I = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_I);
      if (RSP_VALID !== 1'b0 || CYC_O !== 1'b0 || HOST_RDY !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_no_rsp: valid/cyc/rdy got %b%b%b want 001", RSP_VALID, CYC_O, HOST_RDY); end
  endtask

  task automatic test_spurious_ack();
    bit bad = 0;
    @(negedge CLK_I);
    spur_ack = 1'b1;
    @(negedge CLK_I);
    spur_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (RSP_VALID !== 1'b0 || CYC_O !== 1'b0 || HOST_RDY !== 1'b1) bad = 1;
      @(negedge CLK_I);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL spurious_ack: valid/cyc/rdy got %b%b%b want 001", RSP_VALID, CYC_O, HOST_RDY); end
  endtask

  task automatic test_back_to_back();
    logic        we, tg;
    logic [7:0]  adr;
    logic [31:0] wd, rd;
    int          d;
    for (int i = 0; i < 6; i++) begin
      we = 1'($urandom_range(0, 1));
      adr = 8'($urandom);
      wd = $urandom;
      rd = $urandom;
      tg = 1'($urandom_range(0, 1));
      d = $urandom_range(1, (TO < 4) ? TO : 4);
      ack_delay = d; rd_data = rd; rd_tgd = tg;
      send(we, adr, wd, we ? 32'h0 : rd, 1'b0, tg);
      collect(d, d + 1, "b2b");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_backpressure();
    test_reset_mid_bus();
    test_spurious_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
